// File: rtl/note_sequencer_pkg.sv
// Shared constants for the note sequencer: FSM state encoding, rest note, default sizing.
package note_sequencer_pkg;

  localparam int unsigned DEFAULT_DEPTH    = 64;
  localparam int unsigned DEFAULT_AW       = 6;
  localparam int unsigned DEFAULT_SYM_W    = 5;
  localparam int unsigned DEFAULT_TICK_DIV = 50_000_000;

  // Width of a byte delivered by the UART receiver
  localparam int unsigned RX_W = 8;

  // Symbol value meaning silence on the tone generator
  localparam int unsigned REST_NOTE = 0;

  // FSM state encoding
  localparam int unsigned STATE_W   = 3;
  localparam logic [2:0]  ST_IDLE   = 3'd0;
  localparam logic [2:0]  ST_RECORD = 3'd1;
  localparam logic [2:0]  ST_PLAY   = 3'd2;
  localparam logic [2:0]  ST_PAUSED = 3'd3;
  localparam logic [2:0]  ST_FINISH = 3'd4;

endpackage

// File: rtl/note_sequencer_if.sv
// Byte-in / note-out bus between the UART receiver, the sequencer and the tone generator.
//   rx_valid, rx_data : received byte strobe and payload (master -> slave)
//   note_out, note_stb, play_idx : current note, update strobe, slot index (slave -> master)
interface note_sequencer_if
  import note_sequencer_pkg::*;
#(
  parameter int unsigned SYM_W = DEFAULT_SYM_W,
  parameter int unsigned AW    = DEFAULT_AW
);
  logic             rx_valid;
  logic [RX_W-1:0]  rx_data;
  logic [SYM_W-1:0] note_out;
  logic             note_stb;
  logic [AW-1:0]    play_idx;

  modport master (output rx_valid, output rx_data,
                  input  note_out, input  note_stb, input play_idx);
  modport slave  (input  rx_valid, input  rx_data,
                  output note_out, output note_stb, output play_idx);
endinterface

// File: rtl/note_sequencer_ram.sv
// Note storage: DEPTH x SYM_W, one write port, one synchronous read port, no reset.
//   clk          : clock
//   we/waddr/wdata : write strobe, slot, symbol
//   re/raddr     : read strobe, slot
//   rdata        : symbol read, valid the cycle after re
module note_ram #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned AW    = 6,
  parameter int unsigned SYM_W = 5
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [SYM_W-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [SYM_W-1:0] rdata
);
  logic [SYM_W-1:0] mem [DEPTH];

  // Storage array and registered read
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/note_sequencer.sv
// Record/playback engine: stores note symbols strobed in from the UART, replays one per tempo tick.
//   clk, rst  : clock, asynchronous active-low reset
//   bus       : rx byte input, note_out/note_stb/play_idx output (slave modport)
//   rec_en, play_en, loop_en, pause : level controls
//   clear     : pulse, empties the recording while idle
//   rec_len   : notes recorded (0..DEPTH)
//   overflow  : sticky, byte arrived with the recording full
//   done      : pulse, non-looping playback finished
//   busy      : engine not idle
module note_sequencer
  import note_sequencer_pkg::*;
#(
  parameter int unsigned DEPTH    = DEFAULT_DEPTH,
  parameter int unsigned AW       = DEFAULT_AW,
  parameter int unsigned SYM_W    = DEFAULT_SYM_W,
  parameter int unsigned TICK_DIV = DEFAULT_TICK_DIV
) (
  input  logic                clk,
  input  logic                rst,
  note_sequencer_if.slave     bus,
  input  logic                rec_en,
  input  logic                play_en,
  input  logic                loop_en,
  input  logic                pause,
  input  logic                clear,
  output logic [AW:0]         rec_len,
  output logic                overflow,
  output logic                done,
  output logic                busy
);
  localparam int unsigned CW       = $clog2(TICK_DIV);
  localparam logic [CW-1:0] CNT_TOP = CW'(TICK_DIV - 1);
  localparam logic [AW:0]   FULL    = (AW+1)'(DEPTH);
  localparam logic [SYM_W-1:0] REST = SYM_W'(REST_NOTE);

  logic [STATE_W-1:0] state_q, state_d;
  logic [AW:0]        rec_len_q, rec_len_d;
  logic [AW:0]        rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               armed_q, armed_d;
  logic               pend_q, pend_d;
  logic [AW-1:0]      pend_idx_q, pend_idx_d;
  logic [SYM_W-1:0]   note_q, note_d;
  logic               stb_q, stb_d;
  logic [AW-1:0]      idx_q, idx_d;
  logic               ovf_q, ovf_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;

  logic               ram_we, ram_re;
  logic [AW-1:0]      ram_waddr, ram_raddr;
  logic [SYM_W-1:0]   ram_wdata, ram_rdata;
  logic               tick;

  // Upper byte bits are not part of a note symbol
  logic unused_rx_hi;
  assign unused_rx_hi = ^bus.rx_data[RX_W-1:SYM_W];

  note_ram #(.DEPTH(DEPTH), .AW(AW), .SYM_W(SYM_W)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .re    (ram_re),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  assign tick = (cnt_q == CNT_TOP);

  // Next-state, datapath and output decode
  always_comb begin
    state_d    = state_q;
    rec_len_d  = rec_len_q;
    rd_ptr_d   = rd_ptr_q;
    cnt_d      = cnt_q;
    armed_d    = armed_q;
    pend_d     = 1'b0;
    pend_idx_d = pend_idx_q;
    note_d     = note_q;
    stb_d      = 1'b0;
    idx_d      = idx_q;
    ovf_d      = ovf_q;
    done_d     = 1'b0;
    ram_we     = 1'b0;
    ram_waddr  = rec_len_q[AW-1:0];
    ram_wdata  = bus.rx_data[SYM_W-1:0];
    ram_re     = 1'b0;
    ram_raddr  = rd_ptr_q[AW-1:0];

    // A read issued on the previous tick lands on the outputs now
    if (pend_q) begin
      note_d = ram_rdata;
      idx_d  = pend_idx_q;
      stb_d  = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (!play_en) armed_d = 1'b1;
        if (clear) begin
          rec_len_d = '0;
          ovf_d     = 1'b0;
        end else if (play_en && armed_q) begin
          state_d  = ST_PLAY;
          rd_ptr_d = '0;
          cnt_d    = CNT_TOP;
        end else if (rec_en) begin
          state_d = ST_RECORD;
        end
      end

      ST_RECORD: begin
        if (bus.rx_valid) begin
          if (rec_len_q < FULL) begin
            ram_we    = 1'b1;
            rec_len_d = rec_len_q + (AW+1)'(1);
          end else begin
            ovf_d = 1'b1;
          end
        end
        if (!rec_en) state_d = ST_IDLE;
      end

      ST_PLAY, ST_PAUSED: begin
        if (!play_en) begin
          state_d = ST_IDLE;
          note_d  = REST;
          stb_d   = 1'b0;
        end else if (pause) begin
          state_d = ST_PAUSED;
        end else begin
          state_d = ST_PLAY;
          if (tick) begin
            cnt_d = '0;
            if (rec_len_q == '0) begin
              state_d = ST_FINISH;
            end else if (rd_ptr_q < rec_len_q) begin
              ram_re     = 1'b1;
              rd_ptr_d   = rd_ptr_q + (AW+1)'(1);
              pend_d     = 1'b1;
              pend_idx_d = rd_ptr_q[AW-1:0];
            end else if (loop_en) begin
              // Wrap without a gap: slot 0 is read on this same tick
              ram_re     = 1'b1;
              ram_raddr  = '0;
              rd_ptr_d   = (AW+1)'(1);
              pend_d     = 1'b1;
              pend_idx_d = '0;
            end else begin
              state_d = ST_FINISH;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end

      ST_FINISH: begin
        done_d  = 1'b1;
        note_d  = REST;
        state_d = ST_IDLE;
        // play_en must be seen low before another playback may start
        armed_d = 1'b0;
      end

      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      rec_len_q  <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      armed_q    <= 1'b1;
      pend_q     <= 1'b0;
      pend_idx_q <= '0;
      note_q     <= '0;
      stb_q      <= 1'b0;
      idx_q      <= '0;
      ovf_q      <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rec_len_q  <= rec_len_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      armed_q    <= armed_d;
      pend_q     <= pend_d;
      pend_idx_q <= pend_idx_d;
      note_q     <= note_d;
      stb_q      <= stb_d;
      idx_q      <= idx_d;
      ovf_q      <= ovf_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.note_out = note_q;
  assign bus.note_stb = stb_q;
  assign bus.play_idx = idx_q;
  assign rec_len      = rec_len_q;
  assign overflow     = ovf_q;
  assign done         = done_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_note_sequencer.sv
// Directed bench for note_sequencer (DEPTH=8, TICK_DIV=4) with a cycle-stamped note/done scoreboard.
module tb_note_sequencer;
  localparam int unsigned DEPTH    = 8;
  localparam int unsigned AW       = 3;
  localparam int unsigned SYM_W    = 5;
  localparam int unsigned TICK_DIV = 4;

  typedef struct {
    int         cyc;
    logic [4:0] note;
    logic [2:0] idx;
  } exp_t;

  logic clk, rst;
  logic rec_en, play_en, loop_en, pause, clear;
  logic [AW:0] rec_len;
  logic overflow, done, busy;

  note_sequencer_if #(.SYM_W(SYM_W), .AW(AW)) bus ();

  note_sequencer #(.DEPTH(DEPTH), .AW(AW), .SYM_W(SYM_W), .TICK_DIV(TICK_DIV)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .rec_en   (rec_en),
    .play_en  (play_en),
    .loop_en  (loop_en),
    .pause    (pause),
    .clear    (clear),
    .rec_len  (rec_len),
    .overflow (overflow),
    .done     (done),
    .busy     (busy)
  );

  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;
  exp_t note_q[$];
  int   done_q[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_note(input int c, input int n, input int i);
    exp_t e;
    e.cyc  = c;
    e.note = 5'(n);
    e.idx  = 3'(i);
    note_q.push_back(e);
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    step(1);
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    step(1);
    clear = 1'b0;
  endtask

  // Bounded wait for every scheduled note/done to be consumed
  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (note_q.size() == 0 && done_q.size() == 0) break;
      step(1);
    end
    check("drain", 32'(note_q.size() + done_q.size()), 32'd0);
  endtask

  // Scoreboard: every cycle, note_stb/done must match the schedule exactly
  initial begin
    exp_t e;
    logic hit, dhit;
    forever begin
      @(negedge clk);
      if (rst) begin
        while (note_q.size() != 0 && note_q[0].cyc < cyc) void'(note_q.pop_front());
        while (done_q.size() != 0 && done_q[0] < cyc) void'(done_q.pop_front());
        hit  = (note_q.size() != 0) && (note_q[0].cyc == cyc);
        dhit = (done_q.size() != 0) && (done_q[0] == cyc);
        check("note_stb", 32'(bus.note_stb), 32'(hit));
        if (hit) begin
          e = note_q.pop_front();
          check("note_out", 32'(bus.note_out), 32'(e.note));
          check("play_idx", 32'(bus.play_idx), 32'(e.idx));
        end
        check("done", 32'(done), 32'(dhit));
        if (dhit) void'(done_q.pop_front());
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    rst = 1'b0;
    rec_en = 1'b0; play_en = 1'b0; loop_en = 1'b0; pause = 1'b0; clear = 1'b0;
    bus.rx_valid = 1'b0; bus.rx_data = 8'h00;
    step(3);
    rst = 1'b1;
    step(1);

    // Reset state
    check("rst_note_out", 32'(bus.note_out), 32'd0);
    check("rst_busy",     32'(busy),         32'd0);
    check("rst_rec_len",  32'(rec_len),      32'd0);
    check("rst_overflow", 32'(overflow),     32'd0);
    check("rst_play_idx", 32'(bus.play_idx), 32'd0);

    // Record 3,5,7 (upper bits of the last byte are discarded)
    rec_en = 1'b1; step(1);
    send_byte(8'h03); send_byte(8'h05); send_byte(8'hE7);
    rec_en = 1'b0; step(2);
    check("rec3_len",  32'(rec_len), 32'd3);
    check("rec3_busy", 32'(busy),    32'd0);

    // Plain playback, then play_en held high must not replay
    t0 = cyc; play_en = 1'b1;
    push_note(t0 + 3, 3, 0); push_note(t0 + 7, 5, 1); push_note(t0 + 11, 7, 2);
    done_q.push_back(t0 + 15);
    wait_drain(40);
    step(10);
    check("norestart_busy", 32'(busy),         32'd0);
    check("finish_note",    32'(bus.note_out), 32'd0);
    play_en = 1'b0; step(2);

    // Pause for 7 cycles while note 3 is playing
    t0 = cyc; play_en = 1'b1;
    push_note(t0 + 3, 3, 0); push_note(t0 + 14, 5, 1); push_note(t0 + 18, 7, 2);
    done_q.push_back(t0 + 22);
    step(3);
    pause = 1'b1; step(4);
    check("pause_held", 32'(bus.note_out), 32'd3);
    check("pause_busy", 32'(busy),         32'd1);
    step(3);
    pause = 1'b0;
    wait_drain(40);
    play_en = 1'b0; step(2);

    // Loop over two notes, stopped by dropping play_en
    pulse_clear();
    check("clear_len", 32'(rec_len), 32'd0);
    rec_en = 1'b1; step(1);
    send_byte(8'h01); send_byte(8'h02);
    rec_en = 1'b0; step(2);
    loop_en = 1'b1;
    t0 = cyc; play_en = 1'b1;
    push_note(t0 + 3, 1, 0); push_note(t0 + 7, 2, 1); push_note(t0 + 11, 1, 0);
    push_note(t0 + 15, 2, 1); push_note(t0 + 19, 1, 0);
    step(19);
    play_en = 1'b0; step(1);
    check("stop_note", 32'(bus.note_out), 32'd0);
    check("stop_busy", 32'(busy),         32'd0);
    check("loop_q",    32'(note_q.size()), 32'd0);
    loop_en = 1'b0; step(2);

    // Overflow: 10 bytes into 8 slots; clear inside RECORD is ignored
    pulse_clear();
    rec_en = 1'b1; step(1);
    for (int i = 1; i <= 10; i++) send_byte(8'(i));
    check("ovf_len",  32'(rec_len),  32'd8);
    check("ovf_flag", 32'(overflow), 32'd1);
    pulse_clear();
    check("rec_clear_len", 32'(rec_len),  32'd8);
    check("rec_clear_ovf", 32'(overflow), 32'd1);
    rec_en = 1'b0; step(2);
    t0 = cyc; play_en = 1'b1;
    for (int i = 0; i < 8; i++) push_note(t0 + 3 + 4 * i, i + 1, i);
    done_q.push_back(t0 + 35);
    wait_drain(60);
    play_en = 1'b0; step(2);

    // Empty recording: done two cycles after play_en, no replay while held
    pulse_clear();
    check("clr_ovf", 32'(overflow), 32'd0);
    check("clr_len", 32'(rec_len),  32'd0);
    t0 = cyc; play_en = 1'b1;
    done_q.push_back(t0 + 3);
    step(15);
    check("empty_note", 32'(bus.note_out), 32'd0);
    check("empty_busy", 32'(busy),         32'd0);
    wait_drain(5);
    play_en = 1'b0; step(2);

    // Reset in the middle of playback
    rec_en = 1'b1; step(1);
    send_byte(8'h04); send_byte(8'h06);
    rec_en = 1'b0; step(2);
    t0 = cyc; play_en = 1'b1;
    push_note(t0 + 3, 4, 0); push_note(t0 + 7, 6, 1);
    step(5);
    check("pre_rst_note", 32'(bus.note_out), 32'd4);
    rst = 1'b0;
    note_q.delete();
    done_q.delete();
    step(1);
    check("midrst_note", 32'(bus.note_out), 32'd0);
    check("midrst_busy", 32'(busy),         32'd0);
    check("midrst_len",  32'(rec_len),      32'd0);
    check("midrst_done", 32'(done),         32'd0);
    play_en = 1'b0;
    rst = 1'b1;
    step(12);
    check("post_rst_busy", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
